// File: rtl/tpm_pkg.sv
// Shared types and constants for the test pattern monitor: FSM states, result codes
// and the saturating-increment helper used by the hit counters.
package tpm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } tpm_state_e;

    localparam logic [3:0] TPM_SEL_T0  = 4'h0;
    localparam logic [3:0] TPM_SEL_T1  = 4'h1;
    localparam logic [3:0] TPM_SEL_T2  = 4'h2;
    localparam logic [3:0] TPM_SEL_T3  = 4'h3;
    localparam logic [3:0] TPM_SEL_ERR = 4'hF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tpm_if.sv
// Observation bus of the test pattern monitor: stimulus wires in, classification out.
// The master side drives a/b/start (stimulus), the slave side is the monitor.
interface tpm_if;
    logic       start;
    logic       a;
    logic       b;
    logic [3:0] sel_out;
    logic       sel_valid;
    logic       sel_err;
    logic       busy;

    modport master (output start, a, b, input sel_out, sel_valid, sel_err, busy);
    modport slave  (input start, a, b, output sel_out, sel_valid, sel_err, busy);
endinterface

// File: rtl/tpm_hist_cnt.sv
// Single 8-bit hit counter that saturates at 8'hFF; used for the result histogram.
module tpm_hist_cnt
    import tpm_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc_en,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_en) begin
            cnt_d = sat_inc8(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/test_pattern_monitor.sv
// Passive monitor that times the first rising edge of b after a start pulse and
// classifies the observed a/b sequence as test 0..3 or an error. Defining
// TPM_HIST_EN adds the hist/err_cnt result counters.
module test_pattern_monitor
    import tpm_pkg::*;
#(
    parameter int unsigned SHORT_CYC   = 32'd2,
    parameter int unsigned LONG_CYC    = 32'd4,
    parameter int unsigned TIMEOUT_CYC = 32'd8,
    parameter int unsigned CNT_W       = 32'd4
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef TPM_HIST_EN
    output logic [31:0] hist,
    output logic [7:0]  err_cnt,
`endif
    tpm_if.slave        mon
);

    tpm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_s;
    logic             a_q, a_d;
    logic [3:0]       sel_out_q, sel_out_d;
    logic             sel_valid_q, sel_valid_d;
    logic             sel_err_q, sel_err_d;
    logic             busy_q, busy_d;
    logic             done_s;
    logic [3:0]       code_s;

    // Next state and result decision; n_s counts edges since the start edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        sel_out_d   = sel_out_q;
        sel_valid_d = 1'b0;
        sel_err_d   = 1'b0;
        done_s      = 1'b0;
        code_s      = TPM_SEL_ERR;

        if (cnt_q >= CNT_W'(TIMEOUT_CYC)) begin
            n_s = CNT_W'(TIMEOUT_CYC);
        end else begin
            n_s = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (mon.start) begin
                    a_d   = mon.a;
                    cnt_d = CNT_W'(0);
                    if (mon.b) begin
                        done_s = 1'b1;
                    end else begin
                        state_d = MEASURE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MEASURE: begin
                cnt_d = n_s;
                if (mon.a != a_q) begin
                    done_s = 1'b1;
                end else if (mon.b) begin
                    done_s = 1'b1;
                    if (a_q && (n_s == CNT_W'(SHORT_CYC))) begin
                        code_s = TPM_SEL_T0;
                    end else if (!a_q && (n_s == CNT_W'(SHORT_CYC))) begin
                        code_s = TPM_SEL_T1;
                    end else if (a_q && (n_s == CNT_W'(LONG_CYC))) begin
                        code_s = TPM_SEL_T3;
                    end else begin
                        code_s = TPM_SEL_ERR;
                    end
                end else if (n_s == CNT_W'(TIMEOUT_CYC)) begin
                    done_s = 1'b1;
                    code_s = a_q ? TPM_SEL_T2 : TPM_SEL_ERR;
                end else begin
                    state_d = MEASURE;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_s) begin
            state_d     = REPORT;
            sel_out_d   = code_s;
            sel_err_d   = (code_s == TPM_SEL_ERR);
            sel_valid_d = (code_s != TPM_SEL_ERR);
        end else begin
            sel_out_d = sel_out_q;
        end

        busy_d = (state_d == MEASURE);
    end

    // State, counter and registered outputs; reset aborts any measurement.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_W'(0);
            a_q         <= 1'b0;
            sel_out_q   <= 4'h0;
            sel_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            sel_out_q   <= sel_out_d;
            sel_valid_q <= sel_valid_d;
            sel_err_q   <= sel_err_d;
            busy_q      <= busy_d;
        end
    end

    assign mon.sel_out   = sel_out_q;
    assign mon.sel_valid = sel_valid_q;
    assign mon.sel_err   = sel_err_q;
    assign mon.busy      = busy_q;

`ifdef TPM_HIST_EN
    logic report_s;
    assign report_s = (state_q == REPORT);

    for (genvar g = 0; g < 4; g++) begin : g_hist
        tpm_hist_cnt u_hit (
            .clk    (clk),
            .rstn   (rstn),
            .inc_en (report_s && sel_valid_q && (sel_out_q == 4'(g))),
            .cnt    (hist[8*g +: 8])
        );
    end

    tpm_hist_cnt u_err (
        .clk    (clk),
        .rstn   (rstn),
        .inc_en (report_s && sel_err_q),
        .cnt    (err_cnt)
    );
`endif

endmodule
